// File: rtl/control_unit_pipe.sv
// Registered opcode decoder between fetch and execute: one-entry output register,
// multi-cycle divide stall, branch-shadow squashing, external flush and illegal-opcode flag.
module control_unit_pipe #(
    parameter int OPCODE_W      = 4,
    parameter int DIV_LATENCY   = 8,
    parameter int BRANCH_SHADOW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                branch_select,
    output logic                regfile_we,
    output logic                alu_op_b_select,
    output logic                set_flags,
    output logic                mem_we,
    output logic                wb_select,
    output logic [1:0]          extend_select,
    output logic [1:0]          alu_control,
    output logic                illegal_op,
    output logic                div_busy
);

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_FULL     = 2'd1;
    localparam logic [1:0] S_DIV_WAIT = 2'd2;

    localparam int DIV_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam int SH_W  = (BRANCH_SHADOW > 0) ? $clog2(BRANCH_SHADOW + 1) : 1;

    typedef struct packed {
        logic       branch;
        logic       regwe;
        logic [1:0] ext;
        logic       opb;
        logic [1:0] alu;
        logic       flags;
        logic       memwe;
        logic       wb;
        logic       illegal;
    } ctrl_t;

    logic [1:0]       state;
    ctrl_t            word;
    logic [DIV_W-1:0] div_cnt;
    logic [SH_W-1:0]  shadow_cnt;

    ctrl_t dec;
    logic  dec_branch;
    logic  dec_div;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dec        = '0;
        dec_branch = 1'b0;
        dec_div    = 1'b0;
        if (opcode > OPCODE_W'(12)) begin
            dec.illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                4'd1, 4'd2, 4'd3: begin
                    dec.branch = 1'b1;
                    dec.ext    = 2'b10;
                    dec.alu    = 2'b01;
                    dec.flags  = 1'b1;
                    dec_branch = 1'b1;
                end
                4'd4, 4'd5: begin
                    dec.regwe = 1'b1;
                    dec.wb    = 1'b1;
                end
                4'd6, 4'd7: dec.memwe = 1'b1;
                4'd8:       dec.regwe = 1'b1;
                4'd9: begin
                    dec.regwe = 1'b1;
                    dec.ext   = 2'b01;
                    dec.opb   = 1'b1;
                end
                4'd10: begin
                    dec.regwe = 1'b1;
                    dec.alu   = 2'b01;
                end
                4'd11: begin
                    dec.regwe = 1'b1;
                    dec.alu   = 2'b10;
                    dec_div   = 1'b1;
                end
                4'd12: begin
                    dec.regwe = 1'b1;
                    dec.alu   = 2'b11;
                end
                default: dec = '0;
            endcase
        end
    end

    logic accept;
    logic consume;
    logic squash;

    assign in_ready = !rst && !flush && ((state == S_EMPTY) || ((state == S_FULL) && out_ready));
    assign accept   = in_valid && in_ready;
    assign consume  = (state == S_FULL) && out_ready;
    assign squash   = accept && (shadow_cnt != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            word       <= '0;
            div_cnt    <= '0;
            shadow_cnt <= '0;
        end else if (flush) begin
            state      <= S_EMPTY;
            div_cnt    <= '0;
            shadow_cnt <= '0;
        end else if (state == S_DIV_WAIT) begin
            if (div_cnt == '0) state <= S_FULL;
            else               div_cnt <= div_cnt - DIV_W'(1);
        end else if (squash) begin
            shadow_cnt <= shadow_cnt - SH_W'(1);
            if (consume) state <= S_EMPTY;
        end else if (accept) begin
            word <= dec;
            if (dec_branch) shadow_cnt <= SH_W'(BRANCH_SHADOW);
            if (dec_div && DIV_LATENCY > 1) begin
                state   <= S_DIV_WAIT;
                div_cnt <= DIV_W'(DIV_LATENCY - 2);
            end else begin
                state <= S_FULL;
            end
        end else if (consume) begin
            state <= S_EMPTY;
        end
    end

    // A divide word waits in the same register, so every field is gated by out_valid.
    assign out_valid       = (state == S_FULL);
    assign div_busy        = (state == S_DIV_WAIT);
    assign branch_select   = out_valid & word.branch;
    assign regfile_we      = out_valid & word.regwe;
    assign extend_select   = out_valid ? word.ext : 2'b00;
    assign alu_op_b_select = out_valid & word.opb;
    assign alu_control     = out_valid ? word.alu : 2'b00;
    assign set_flags       = out_valid & word.flags;
    assign mem_we          = out_valid & word.memwe;
    assign wb_select       = out_valid & word.wb;
    assign illegal_op      = out_valid & word.illegal;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: table of decode vectors plus hand-written
// divide, branch-shadow, back-pressure, flush and reset sequences.
module tb_control_unit_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, flush, out_ready;
    logic [3:0] opcode;

    logic in_ready, out_valid, branch_select, regfile_we, alu_op_b_select;
    logic set_flags, mem_we, wb_select, illegal_op, div_busy;
    logic [1:0] extend_select, alu_control;

    logic in_ready0, out_valid0, branch_select0, regfile_we0, alu_op_b_select0;
    logic set_flags0, mem_we0, wb_select0, illegal_op0, div_busy0;
    logic [1:0] extend_select0, alu_control0;

    always #5 clk = ~clk;

    control_unit_pipe #(.OPCODE_W(4), .DIV_LATENCY(8), .BRANCH_SHADOW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .branch_select(branch_select), .regfile_we(regfile_we),
        .alu_op_b_select(alu_op_b_select), .set_flags(set_flags), .mem_we(mem_we),
        .wb_select(wb_select), .extend_select(extend_select), .alu_control(alu_control),
        .illegal_op(illegal_op), .div_busy(div_busy)
    );

    // Same stimulus, branch shadow disabled.
    control_unit_pipe #(.OPCODE_W(4), .DIV_LATENCY(8), .BRANCH_SHADOW(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .in_ready(in_ready0),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .branch_select(branch_select0), .regfile_we(regfile_we0),
        .alu_op_b_select(alu_op_b_select0), .set_flags(set_flags0), .mem_we(mem_we0),
        .wb_select(wb_select0), .extend_select(extend_select0), .alu_control(alu_control0),
        .illegal_op(illegal_op0), .div_busy(div_busy0)
    );

    // {branch, regwe, ext[1:0], opb, alu[1:0], flags, memwe, wb}
    localparam logic [9:0] C_NOP  = 10'b0000000000;
    localparam logic [9:0] C_BR   = 10'b1010001100;
    localparam logic [9:0] C_LD   = 10'b0100000001;
    localparam logic [9:0] C_ST   = 10'b0000000010;
    localparam logic [9:0] C_ADD  = 10'b0100000000;
    localparam logic [9:0] C_ADDI = 10'b0101100000;
    localparam logic [9:0] C_SUB  = 10'b0100001000;
    localparam logic [9:0] C_DIV  = 10'b0100010000;
    localparam logic [9:0] C_SHL  = 10'b0100011000;

    logic [9:0] ctrl, ctrl0;
    assign ctrl  = {branch_select, regfile_we, extend_select, alu_op_b_select,
                    alu_control, set_flags, mem_we, wb_select};
    assign ctrl0 = {branch_select0, regfile_we0, extend_select0, alu_op_b_select0,
                    alu_control0, set_flags0, mem_we0, wb_select0};

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic       ev;
        logic       eir;
        logic [9:0] ectrl;
        logic       eill;
    } vec_t;

    vec_t tbl[11];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   busy_cycles;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one cycle: drive inputs after the rising edge, return at the falling edge to sample.
    task automatic cyc(input logic r, input logic v, input logic [3:0] op,
                       input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        opcode    = op;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    // {out_valid, in_ready, div_busy, illegal_op, ctrl}
    function automatic logic [15:0] pk(input logic ov, input logic ir, input logic b,
                                       input logic il, input logic [9:0] c);
        return {2'b00, ov, ir, b, il, c};
    endfunction

    logic [15:0] obs;
    logic [15:0] obs0;
    assign obs  = pk(out_valid, in_ready, div_busy, illegal_op, ctrl);
    assign obs0 = pk(out_valid0, in_ready0, div_busy0, illegal_op0, ctrl0);

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; out_ready = 1'b1; flush = 1'b0;

        tbl[0]  = '{1'b1, 4'd8,  1'b0, 1'b1, C_NOP,  1'b0};
        tbl[1]  = '{1'b1, 4'd9,  1'b1, 1'b1, C_ADD,  1'b0};
        tbl[2]  = '{1'b1, 4'd10, 1'b1, 1'b1, C_ADDI, 1'b0};
        tbl[3]  = '{1'b1, 4'd12, 1'b1, 1'b1, C_SUB,  1'b0};
        tbl[4]  = '{1'b1, 4'd0,  1'b1, 1'b1, C_SHL,  1'b0};
        tbl[5]  = '{1'b1, 4'd14, 1'b1, 1'b1, C_NOP,  1'b0};
        tbl[6]  = '{1'b1, 4'd4,  1'b1, 1'b1, C_NOP,  1'b1};
        tbl[7]  = '{1'b1, 4'd7,  1'b1, 1'b1, C_LD,   1'b0};
        tbl[8]  = '{1'b1, 4'd13, 1'b1, 1'b1, C_ST,   1'b0};
        tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, C_NOP,  1'b1};
        tbl[10] = '{1'b0, 4'd0,  1'b0, 1'b1, C_NOP,  1'b0};

        // Reset state
        cyc(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        check("reset", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, C_NOP));

        // Streaming decode table, one instruction per cycle
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, tbl[i].v, tbl[i].op, 1'b1, 1'b0);
            check($sformatf("table[%0d]", i), obs,
                  pk(tbl[i].ev, tbl[i].eir, 1'b0, tbl[i].eill, tbl[i].ectrl));
        end

        // Divide stall followed by add, accepted as the div word is consumed
        cyc(1'b0, 1'b1, 4'd11, 1'b1, 1'b0);
        check("div_accept", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        busy_cycles = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
            if (div_busy === 1'b1) busy_cycles++;
            check($sformatf("div_wait[%0d]", k), obs, pk(1'b0, 1'b0, 1'b1, 1'b0, C_NOP));
        end
        check("div_busy_cycles", 16'(busy_cycles), 16'd7);
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        check("div_word", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_DIV));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("add_after_div", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_ADD));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("div_drain", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));

        // Branch shadow: shadow=2 squashes 8,10; shadow=0 presents everything
        cyc(1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        check("br_accept", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        check("br_word", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_BR));
        check("br_word_sh0", obs0, pk(1'b1, 1'b1, 1'b0, 1'b0, C_BR));
        cyc(1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        check("squash_8", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        check("sh0_add", obs0, pk(1'b1, 1'b1, 1'b0, 1'b0, C_ADD));
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        check("squash_10", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        check("sh0_sub", obs0, pk(1'b1, 1'b1, 1'b0, 1'b0, C_SUB));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("after_shadow_addi", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_ADDI));
        check("sh0_addi", obs0, pk(1'b1, 1'b1, 1'b0, 1'b0, C_ADDI));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("shadow_drain", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));

        // Back-pressure for 5 cycles, then flush drops the held word
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
            check($sformatf("hold[%0d]", k), obs, pk(1'b1, 1'b0, 1'b0, 1'b0, C_ADD));
        end
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
        check("flush_cycle", obs, pk(1'b1, 1'b0, 1'b0, 1'b0, C_ADD));
        cyc(1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        check("after_flush", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("post_flush_sub", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_SUB));

        // Flush in the last DIV_WAIT cycle: no divide word ever appears
        cyc(1'b0, 1'b1, 4'd11, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("div_last_flush", obs, pk(1'b0, 1'b0, 1'b1, 1'b0, C_NOP));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("div_flushed", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        check("div_flushed2", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("post_div_flush_shl", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_SHL));

        // Reset during an active branch shadow clears it
        cyc(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        check("br2_word", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_BR));
        cyc(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        check("rst_in_shadow", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        check("rst_release", obs, pk(1'b0, 1'b1, 1'b0, 1'b0, C_NOP));
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("post_rst_add", obs, pk(1'b1, 1'b1, 1'b0, 1'b0, C_ADD));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
